// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO and registered result slot wrapped around a combinational ALU
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_opcode,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [$clog2(WIDTH)-1:0]  in_shamt,
  output logic [3:0]                alu_opcode,
  output logic [WIDTH-1:0]          alu_in1,
  output logic [WIDTH-1:0]          alu_in2,
  output logic [$clog2(WIDTH)-1:0]  alu_shift,
  input  logic [WIDTH-1:0]          alu_result,
  input  logic                      alu_carry,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_result,
  output logic                      out_carry,
  output logic                      out_divz,
  output logic [3:0]                out_opcode,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int sw = $clog2(WIDTH);
  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] full_count = (aw + 1)'(DEPTH);

  logic [3:0]       op_mem [DEPTH];
  logic [WIDTH-1:0] a_mem  [DEPTH];
  logic [WIDTH-1:0] b_mem  [DEPTH];
  logic [sw-1:0]    sh_mem [DEPTH];

  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_arith;
  logic          head_divz;

  assign empty    = (fifo_count == '0);
  // No full-bypass: a full FIFO refuses a push even when it pops this cycle.
  assign in_ready = (fifo_count < full_count);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= in_opcode;
      a_mem[wr_ptr]  <= in_a;
      b_mem[wr_ptr]  <= in_b;
      sh_mem[wr_ptr] <= in_shamt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (aw + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (aw + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The ALU sees zeros while nothing is buffered, so it never computes on stale entries.
  assign alu_opcode = empty ? '0 : op_mem[rd_ptr];
  assign alu_in1    = empty ? '0 : a_mem[rd_ptr];
  assign alu_in2    = empty ? '0 : b_mem[rd_ptr];
  assign alu_shift  = empty ? '0 : sh_mem[rd_ptr];

  assign head_arith = (alu_opcode == 4'd4) || (alu_opcode == 4'd5);
  assign head_divz  = (alu_opcode == 4'd6) && (alu_in2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_divz   <= 1'b0;
      out_opcode <= '0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= alu_opcode;
      out_carry  <= head_arith && alu_carry;
      out_divz   <= head_divz;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed table-driven bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
  localparam int W = 32;
  localparam int D = 4;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         c;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         dz;
    logic [3:0]   op;
    int           cyc;
  } got_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [4:0]   in_shamt;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [4:0]   alu_shift;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_divz;
  logic [3:0]   out_opcode;
  logic [2:0]   fifo_count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  got_t got_q[$];
  vec_t t2[8];
  vec_t t3[5];
  vec_t extra;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_divz(out_divz), .out_opcode(out_opcode),
    .fifo_count(fifo_count)
  );

  // Carry is driven high on non-arithmetic ops so the stage's carry masking is observable.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b1;
    case (alu_opcode)
      4'd0: alu_result = (alu_in1 << alu_shift) | (alu_in1 >> (6'd32 - {1'b0, alu_shift}));
      4'd1: alu_result = (alu_in1 >> alu_shift) | (alu_in1 << (6'd32 - {1'b0, alu_shift}));
      4'd2: alu_result = (alu_in1 > alu_in2) ? alu_in1 : alu_in2;
      4'd3: alu_result = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
      4'd4: {alu_carry, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'd5: begin
        alu_result = alu_in1 - alu_in2;
        alu_carry  = alu_in1 < alu_in2;
      end
      4'd6: alu_result = (alu_in2 == '0) ? '0 : alu_in1 / alu_in2;
      4'd7: alu_result = ~(alu_in1 | alu_in2);
      4'd8: alu_result = alu_in1 | alu_in2;
      default: alu_result = '0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back('{res: out_result, c: out_carry, dz: out_divz, op: out_opcode, cyc: cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_a      = v.a;
    in_b      = v.b;
    in_shamt  = v.sh;
  endtask

  task automatic chk_got(input string name, input int idx, input vec_t v);
    if (idx < got_q.size()) begin
      chk({name, "_res"}, got_q[idx].res, v.res);
      chk({name, "_carry"}, 32'(got_q[idx].c), 32'(v.c));
      chk({name, "_divz"}, 32'(got_q[idx].dz), 32'(v.dz));
      chk({name, "_op"}, 32'(got_q[idx].op), 32'(v.op));
    end else begin
      chk({name, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    t2[0] = '{op: 4'd5, a: 32'd5,          b: 32'd3,          sh: 5'd0, res: 32'd2,          c: 1'b0, dz: 1'b0};
    t2[1] = '{op: 4'd0, a: 32'h8000_0001,  b: 32'd0,          sh: 5'd1, res: 32'h0000_0003,  c: 1'b0, dz: 1'b0};
    t2[2] = '{op: 4'd2, a: 32'd7,          b: 32'd9,          sh: 5'd0, res: 32'd9,          c: 1'b0, dz: 1'b0};
    t2[3] = '{op: 4'd6, a: 32'd10,         b: 32'd0,          sh: 5'd0, res: 32'd0,          c: 1'b0, dz: 1'b1};
    t2[4] = '{op: 4'd7, a: 32'd0,          b: 32'd0,          sh: 5'd0, res: 32'hFFFF_FFFF,  c: 1'b0, dz: 1'b0};
    t2[5] = '{op: 4'd8, a: 32'hF0,         b: 32'h0F,         sh: 5'd0, res: 32'hFF,         c: 1'b0, dz: 1'b0};
    t2[6] = '{op: 4'd3, a: 32'd7,          b: 32'd9,          sh: 5'd0, res: 32'd7,          c: 1'b0, dz: 1'b0};
    t2[7] = '{op: 4'd1, a: 32'd1,          b: 32'd0,          sh: 5'd1, res: 32'h8000_0000,  c: 1'b0, dz: 1'b0};
    t3[0] = '{op: 4'd4, a: 32'd1,          b: 32'd100,        sh: 5'd0, res: 32'd101,        c: 1'b0, dz: 1'b0};
    t3[1] = '{op: 4'd5, a: 32'd50,         b: 32'd8,          sh: 5'd0, res: 32'd42,         c: 1'b0, dz: 1'b0};
    t3[2] = '{op: 4'd8, a: 32'd3,          b: 32'd4,          sh: 5'd0, res: 32'd7,          c: 1'b0, dz: 1'b0};
    t3[3] = '{op: 4'd2, a: 32'd11,         b: 32'd2,          sh: 5'd0, res: 32'd11,         c: 1'b0, dz: 1'b0};
    t3[4] = '{op: 4'd0, a: 32'd1,          b: 32'd0,          sh: 5'd4, res: 32'd16,         c: 1'b0, dz: 1'b0};
    extra = '{op: 4'd4, a: 32'd2,          b: 32'd3,          sh: 5'd0, res: 32'd5,          c: 1'b0, dz: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_shamt = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_opcode", 32'(out_opcode), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);

    // 1: single ADD with carry out, 2-cycle latency
    drive('{op: 4'd4, a: 32'hFFFF_FFFF, b: 32'd1, sh: 5'd0, res: 32'd0, c: 1'b1, dz: 1'b0});
    #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_alu_opcode", 32'(alu_opcode), 32'd4);
    chk("t1_alu_in1", alu_in1, 32'hFFFF_FFFF);
    chk("t1_alu_in2", alu_in2, 32'd1);
    chk("t1_out_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_result", out_result, 32'd0);
    chk("t1_out_carry", 32'(out_carry), 32'd1);
    chk("t1_out_opcode", 32'(out_opcode), 32'd4);
    tick();
    chk("t1_out_valid_after", 32'(out_valid), 32'd0);

    // 2: back-to-back stream, one result per cycle in order
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(t2[i]);
      #1 chk($sformatf("t2_in_ready_%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t2_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk_got($sformatf("t2_%0d", i), i, t2[i]);
      if (i < got_q.size())
        chk($sformatf("t2_cyc_%0d", i), 32'(got_q[i].cyc - got_q[0].cyc), 32'(i));
    end

    // 3: stalled consumer fills the FIFO, then drains in order
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(t3[i]);
      tick();
    end
    drive(extra);
    #1;
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    chk("t3_slot_result", out_result, t3[0].res);
    tick();
    chk("t3_count_hold", 32'(fifo_count), 32'd4);
    chk("t3_slot_stable", out_result, t3[0].res);
    chk("t3_slot_op_stable", 32'(out_opcode), 32'(t3[0].op));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_count_3", 32'(fifo_count), 32'd3);
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);
    repeat (6) tick();
    chk("t3_drained", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_got($sformatf("t3_%0d", i), i, t3[i]);

    // 4: full FIFO with pop in the same cycle still refuses the push
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(t3[i]);
      tick();
    end
    out_ready = 1'b1;
    drive(extra);
    #1;
    chk("t4_in_ready_nobypass", 32'(in_ready), 32'd0);
    chk("t4_count_full", 32'(fifo_count), 32'd4);
    tick();
    chk("t4_count_3", 32'(fifo_count), 32'd3);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("t4_count_pushpop", 32'(fifo_count), 32'd3);
    repeat (6) tick();
    chk("t4_drained", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 5; i++) chk_got($sformatf("t4_%0d", i), i, t3[i]);
    chk_got("t4_extra", 5, extra);

    // 5: reset mid-stream discards buffered commands and the pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(t3[i]);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t5_count_pre", 32'(fifo_count), 32'd3);
    chk("t5_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_result", out_result, 32'd0);
    chk("t5_rst_opcode", 32'(out_opcode), 32'd0);
    chk("t5_rst_alu_in1", alu_in1, 32'd0);
    tick();
    rst_n = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    drive('{op: 4'd4, a: 32'd2, b: 32'd2, sh: 5'd0, res: 32'd4, c: 1'b0, dz: 1'b0});
    #1 chk("t5_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_valid_early", 32'(out_valid), 32'd0);
    chk("t5_alu_in1", alu_in1, 32'd2);
    tick();
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_result", out_result, 32'd4);
    repeat (4) tick();
    chk("t5_no_stale", 32'(got_q.size()), 32'd1);

    // 6: unassigned opcode passes through with carry/divz forced low
    drive('{op: 4'd12, a: 32'd5, b: 32'd5, sh: 5'd0, res: 32'd0, c: 1'b0, dz: 1'b0});
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_result", out_result, 32'd0);
    chk("t6_carry", 32'(out_carry), 32'd0);
    chk("t6_divz", 32'(out_divz), 32'd0);
    chk("t6_opcode", 32'(out_opcode), 32'd12);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
